// File: rtl/lane_vrf_bank.sv
// lane_vrf_bank: one lane's slice of the vector register file.
// Two read ports share one element address. There is also one write port.
// After reset the bank clears every entry, one entry per cycle, before it reports ready.
// Optional feature: define LANE_VRF_BANK_BYPASS_EN so that a read of an entry
// being written in the same cycle returns the incoming write data.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module lane_vrf_bank #(
    parameter int els_p   = 32,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 8,
    parameter int lanes_p = 2,
    localparam int depth_lp            = vlen_p / lanes_p,
    localparam int v_addr_width_lp     = `BSG_SAFE_CLOG2(els_p),
    localparam int local_addr_width_lp = `BSG_SAFE_CLOG2(vlen_p),
    localparam int id_width_lp         = `BSG_SAFE_CLOG2(lanes_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [id_width_lp-1:0]         my_id_i,
    output logic                           ready_o,
    input  logic                           r_v_i,
    input  logic [v_addr_width_lp-1:0]     r0_vreg_i,
    input  logic [v_addr_width_lp-1:0]     r1_vreg_i,
    input  logic [local_addr_width_lp-1:0] r_addr_i,
    output logic                           r_v_o,
    output logic [vdw_p-1:0]               r0_data_o,
    output logic [vdw_p-1:0]               r1_data_o,
    input  logic                           w_en_i,
    input  logic [v_addr_width_lp-1:0]     w_vreg_i,
    input  logic [local_addr_width_lp-1:0] w_addr_i,
    input  logic [vdw_p-1:0]               w_data_i,
    output logic                           addr_err_o
);

    localparam int entries_lp     = els_p * depth_lp;
    localparam int entry_width_lp = `BSG_SAFE_CLOG2(entries_lp);
    localparam int lane_shift_lp  = $clog2(lanes_p);

    localparam logic state_init  = 1'b0;
    localparam logic state_ready = 1'b1;

    logic                      state;
    logic [entry_width_lp-1:0] init_cnt;
    logic [vdw_p-1:0]          mem [entries_lp];

    logic [entry_width_lp-1:0] r0_entry, r1_entry, w_entry;
    logic                      r_owned, w_owned;
    logic                      do_write, do_read;
    logic [vdw_p-1:0]          r0_next, r1_next;

    // The element row is the element index with the lane-select bits removed.
    function automatic logic [entry_width_lp-1:0] entry_of(
        input logic [v_addr_width_lp-1:0]     vreg,
        input logic [local_addr_width_lp-1:0] addr
    );
        logic [local_addr_width_lp-1:0] row;
        row = addr >> lane_shift_lp;
        return entry_width_lp'(int'(vreg) * depth_lp + int'(row));
    endfunction

    // A lane owns an element index when the low index bits match its id.
    function automatic logic owned(
        input logic [local_addr_width_lp-1:0] addr,
        input logic [id_width_lp-1:0]         id
    );
        if (lanes_p == 1) return 1'b1;
        return addr[id_width_lp-1:0] == id;
    endfunction

    assign ready_o  = (state == state_ready);
    assign r0_entry = entry_of(r0_vreg_i, r_addr_i);
    assign r1_entry = entry_of(r1_vreg_i, r_addr_i);
    assign w_entry  = entry_of(w_vreg_i, w_addr_i);
    assign r_owned  = owned(r_addr_i, my_id_i);
    assign w_owned  = owned(w_addr_i, my_id_i);
    assign do_write = ready_o && w_en_i && w_owned;
    assign do_read  = ready_o && r_v_i;

    // Select the read data for each port. Unowned reads return zero. The optional
    // bypass forwards write data to a port that reads the entry being written.
    always_comb begin
        r0_next = '0;
        r1_next = '0;
        if (r_owned) begin
            r0_next = mem[r0_entry];
            r1_next = mem[r1_entry];
`ifdef LANE_VRF_BANK_BYPASS_EN
            if (do_write && (w_entry == r0_entry)) r0_next = w_data_i;
            if (do_write && (w_entry == r1_entry)) r1_next = w_data_i;
`endif
        end
    end

    // Sequence INIT: clear one entry per cycle, then move to READY after the last entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= state_init;
            init_cnt <= '0;
        end else if (state == state_init) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == entry_width_lp'(entries_lp - 1)) state <= state_ready;
        end
    end

    // Storage array. During INIT, zero the entry the counter points at. In READY,
    // store owned writes.
    always_ff @(posedge clk_i) begin
        if (state == state_init) mem[init_cnt] <= '0;
        else if (do_write)       mem[w_entry]  <= w_data_i;
    end

    // Register the read response one cycle after the request. The data holds
    // its value between reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v_o     <= 1'b0;
            r0_data_o <= '0;
            r1_data_o <= '0;
        end else if (do_read) begin
            r_v_o     <= 1'b1;
            r0_data_o <= r0_next;
            r1_data_o <= r1_next;
        end else begin
            r_v_o <= 1'b0;
        end
    end

    // Sticky flag for any read or write to an element index that another lane
    // owns. Only reset clears it.
    always_ff @(posedge clk_i) begin
        if (reset_i)                                            addr_err_o <= 1'b0;
        else if (ready_o && ((w_en_i && !w_owned) || (r_v_i && !r_owned))) addr_err_o <= 1'b1;
    end

endmodule
